// File: rtl/hazard_control_unit.sv
// hazard_control_unit: pipeline stall/flush/hold control; optional stall statistic under HAZARD_CONTROL_STATS_EN
module hazard_control_unit #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rs_valid,
    input  logic                  id_rt_valid,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  branch_taken,
    input  logic                  mem_busy,
    output logic                  pc_write_en,
    output logic                  ifid_write_en,
    output logic                  bubble_sel,
    output logic                  ifid_flush,
    output logic                  pipe_hold,
    output logic                  mem_timeout
`ifdef HAZARD_CONTROL_STATS_EN
    ,
    output logic [15:0]           stall_cycles
`endif
);
    typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;
    state_t state, state_nx;
    logic [1:0] stall_cnt, stall_cnt_nx;
    logic [7:0] wait_cnt, wait_cnt_nx;
    logic hazard;
    assign hazard = ex_mem_read && (ex_rd != '0) &&
                    ((id_rs_valid && id_rs == ex_rd) || (id_rt_valid && id_rt == ex_rd));
    always_comb begin
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        bubble_sel    = 1'b0;
        ifid_flush    = 1'b0;
        pipe_hold     = 1'b0;
        state_nx      = RUN;
        stall_cnt_nx  = stall_cnt;
        wait_cnt_nx   = '0;
        if (mem_busy) begin
            pipe_hold     = 1'b1;
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            state_nx      = MEM_WAIT;
            wait_cnt_nx   = (wait_cnt == 8'(MEM_TIMEOUT)) ? wait_cnt : wait_cnt + 8'd1;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
            bubble_sel = 1'b1;
        end else if (state == LOAD_STALL || hazard) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            bubble_sel    = 1'b1;
            stall_cnt_nx  = (state == LOAD_STALL) ? stall_cnt - 2'd1 : 2'(LOAD_STALL_CYCLES - 1);
            state_nx      = (state == LOAD_STALL) ? ((stall_cnt == 2'd1) ? RUN : LOAD_STALL)
                                                  : ((LOAD_STALL_CYCLES > 1) ? LOAD_STALL : RUN);
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RUN;
            stall_cnt   <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state     <= state_nx;
            stall_cnt <= stall_cnt_nx;
            wait_cnt  <= wait_cnt_nx;
            if (wait_cnt_nx == 8'(MEM_TIMEOUT))
                mem_timeout <= 1'b1;
        end
    end
`ifdef HAZARD_CONTROL_STATS_EN
    always_ff @(posedge clock) begin
        if (reset)
            stall_cycles <= '0;
        else if (!pc_write_en && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
    end
`else
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed checks of stall/flush/hold/timeout behaviour for two stall depths
module tb_hazard_control_unit;
    logic clock = 1'b0;
    logic reset;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic id_rs_valid, id_rt_valid, ex_mem_read, branch_taken, mem_busy;
    logic pc_a, ifid_a, bub_a, fl_a, hold_a, to_a;
    logic pc_b, ifid_b, bub_b, fl_b, hold_b, to_b;
`ifdef HAZARD_CONTROL_STATS_EN
    logic [15:0] sc_a, sc_b;
`endif
    logic [4:0] outs_a, outs_b;
    int checks = 0;
    int errors = 0;
    localparam logic [4:0] RUNO  = 5'b11000;
    localparam logic [4:0] STALL = 5'b00100;
    localparam logic [4:0] FLUSH = 5'b11110;
    localparam logic [4:0] HOLD  = 5'b00001;

    assign outs_a = {pc_a, ifid_a, bub_a, fl_a, hold_a};
    assign outs_b = {pc_b, ifid_b, bub_b, fl_b, hold_b};

    always #5 clock = ~clock;

    hazard_control_unit #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(15)) dut_a (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_valid(id_rs_valid), .id_rt_valid(id_rt_valid), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write_en(pc_a), .ifid_write_en(ifid_a), .bubble_sel(bub_a),
        .ifid_flush(fl_a), .pipe_hold(hold_a), .mem_timeout(to_a)
`ifdef HAZARD_CONTROL_STATS_EN
        , .stall_cycles(sc_a)
`endif
    );

    hazard_control_unit #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(15)) dut_b (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_valid(id_rs_valid), .id_rt_valid(id_rt_valid), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write_en(pc_b), .ifid_write_en(ifid_b), .bubble_sel(bub_b),
        .ifid_flush(fl_b), .pipe_hold(hold_b), .mem_timeout(to_b)
`ifdef HAZARD_CONTROL_STATS_EN
        , .stall_cycles(sc_b)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs, input logic rsv,
                         input logic [4:0] rt, input logic rtv, input logic br, input logic mb);
        ex_mem_read = mr; ex_rd = rd; id_rs = rs; id_rs_valid = rsv;
        id_rt = rt; id_rt_valid = rtv; branch_taken = br; mem_busy = mb;
        #1;
    endtask

    task automatic idle;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        idle();
        chk("reset_outs_a", 16'(outs_a), 16'(RUNO));
        chk("reset_outs_b", 16'(outs_b), 16'(RUNO));
        chk("reset_timeout_a", 16'(to_a), 16'd0);
        chk("reset_timeout_b", 16'(to_b), 16'd0);
        drive(1, 5, 5, 1, 0, 0, 0, 0);
        chk("load_use_c1_a", 16'(outs_a), 16'(STALL));
        chk("load_use_c1_b", 16'(outs_b), 16'(STALL));
        tick();
        idle();
        chk("load_use_c2_a", 16'(outs_a), 16'(RUNO));
        chk("load_use_c2_b", 16'(outs_b), 16'(STALL));
        tick();
        idle();
        chk("load_use_c3_a", 16'(outs_a), 16'(RUNO));
        chk("load_use_c3_b", 16'(outs_b), 16'(STALL));
        tick();
        idle();
        chk("load_use_done_b", 16'(outs_b), 16'(RUNO));
        tick();
        drive(1, 5, 5, 1, 0, 0, 0, 0);
        chk("abandon_c1_b", 16'(outs_b), 16'(STALL));
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("abandon_c2_a", 16'(outs_a), 16'(FLUSH));
        chk("abandon_c2_b", 16'(outs_b), 16'(FLUSH));
        tick();
        idle();
        chk("abandon_c3_a", 16'(outs_a), 16'(RUNO));
        chk("abandon_c3_b", 16'(outs_b), 16'(RUNO));
        drive(1, 7, 3, 1, 7, 0, 0, 0);
        chk("rt_invalid_a", 16'(outs_a), 16'(RUNO));
        drive(0, 7, 7, 1, 7, 1, 0, 0);
        chk("not_load_a", 16'(outs_a), 16'(RUNO));
        drive(1, 0, 0, 1, 0, 1, 0, 0);
        chk("rd_zero_a", 16'(outs_a), 16'(RUNO));
        chk("rd_zero_b", 16'(outs_b), 16'(RUNO));
        drive(1, 5, 5, 0, 0, 0, 0, 0);
        chk("rs_invalid_a", 16'(outs_a), 16'(RUNO));
        drive(1, 7, 3, 1, 7, 1, 0, 0);
        chk("rt_hazard_a", 16'(outs_a), 16'(STALL));
        chk("rt_hazard_b", 16'(outs_b), 16'(STALL));
        tick();
        reset = 1'b1;
        idle();
        chk("pre_reset_stall_b", 16'(outs_b), 16'(STALL));
        tick();
        reset = 1'b0;
        idle();
        chk("mid_stall_reset_a", 16'(outs_a), 16'(RUNO));
        chk("mid_stall_reset_b", 16'(outs_b), 16'(RUNO));
        drive(1, 5, 5, 1, 0, 0, 1, 0);
        chk("branch_over_hazard_a", 16'(outs_a), 16'(FLUSH));
        chk("branch_over_hazard_b", 16'(outs_b), 16'(FLUSH));
        tick();
        drive(1, 5, 5, 1, 0, 0, 1, 1);
        chk("all_events_a", 16'(outs_a), 16'(HOLD));
        chk("all_events_b", 16'(outs_b), 16'(HOLD));
        tick();
        drive(1, 5, 5, 1, 0, 0, 0, 0);
        chk("redetect_a", 16'(outs_a), 16'(STALL));
        chk("redetect_b", 16'(outs_b), 16'(STALL));
        tick();
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1);
            chk($sformatf("busy_hold_%0d", k), 16'(outs_a), 16'(HOLD));
            chk($sformatf("busy_timeout_%0d", k), 16'(to_a), (k > 15) ? 16'd1 : 16'd0);
            tick();
        end
        idle();
        chk("after_busy_outs_a", 16'(outs_a), 16'(RUNO));
        chk("timeout_sticky_a", 16'(to_a), 16'd1);
        chk("timeout_sticky_b", 16'(to_b), 16'd1);
        tick();
        chk("timeout_sticky2_a", 16'(to_a), 16'd1);
        do_reset();
        idle();
        chk("timeout_cleared_a", 16'(to_a), 16'd0);
`ifdef HAZARD_CONTROL_STATS_EN
        chk("stats_reset_a", sc_a, 16'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 5, 5, 1, 0, 0, 0, 0);
            tick();
            idle();
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1);
            tick();
        end
        idle();
        chk("stats_total_a", sc_a, 16'd10);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-address width.
REQ-002 SHALL have parameter LOAD_STALL_CYCLES, default 1, bubble cycles per load-use hazard (range 1-3).
REQ-003 SHALL have parameter MEM_TIMEOUT, default 15, maximum consecutive mem_busy cycles before error (range 1-255).
REQ-004 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 SHALL have ports id_rs and id_rt, input, REG_ADDR_W each, source registers of the instruction in ID.
REQ-007 SHALL have ports id_rs_valid and id_rt_valid, input, 1 each, source actually read.
REQ-008 SHALL have ports ex_rd, input, REG_ADDR_W, and ex_mem_read, input, 1: destination and load flag of the instruction in EX.
REQ-009 SHALL have port branch_taken, input, 1, branch/jump resolved taken in EX this cycle.
REQ-010 SHALL have port mem_busy, input, 1, data memory not ready.
REQ-011 SHALL have ports pc_write_en, output, 1, and ifid_write_en, output, 1: write enables for PC and IF/ID.
REQ-012 SHALL have port bubble_sel, output, 1, select of the downstream 1-bit control muxes; 1 selects zeroed control into ID/EX.
REQ-013 SHALL have ports ifid_flush, output, 1, clears IF/ID; pipe_hold, output, 1, freezes ID/EX, EX/MEM, MEM/WB.
REQ-014 SHALL have port mem_timeout, output, 1, sticky error flag.

Function
REQ-015 SHALL implement FSM states RUN, LOAD_STALL, MEM_WAIT.
REQ-016 SHALL define hazard = ex_mem_read and ex_rd != 0 and ((id_rs_valid and id_rs == ex_rd) or (id_rt_valid and id_rt == ex_rd)).
REQ-017 SHALL drive outputs combinationally from current state and inputs; event priority mem_busy > branch_taken > hazard.
REQ-018 In any state, when mem_busy=1: pipe_hold=1, pc_write_en=0, ifid_write_en=0, bubble_sel=0, ifid_flush=0; next state MEM_WAIT; the wait counter increments.
REQ-019 RUN, mem_busy=0, branch_taken=1: ifid_flush=1, bubble_sel=1, pc_write_en=1, ifid_write_en=1; stay RUN.
REQ-020 RUN, hazard only: pc_write_en=0, ifid_write_en=0, bubble_sel=1; load stall counter with LOAD_STALL_CYCLES-1; go to LOAD_STALL if LOAD_STALL_CYCLES>1, else stay RUN.
REQ-021 RUN, no event: pc_write_en=1, ifid_write_en=1, all other outputs 0.
REQ-022 LOAD_STALL, mem_busy=0: same outputs as REQ-020; decrement counter; go to RUN when counter reaches 0; branch_taken in this state behaves as REQ-019, abandons the stall and goes to RUN.
REQ-023 MEM_WAIT, mem_busy=0: return to RUN, clear the wait counter, and evaluate RUN rules that same cycle; an interrupted load stall is re-detected, not resumed.
REQ-024 Wait counter SHALL saturate at MEM_TIMEOUT; mem_timeout SHALL set on the cycle the counter reaches MEM_TIMEOUT and hold until reset.
REQ-025 ex_rd == 0 SHALL never produce a hazard.

Reset
REQ-026 While reset=1 at a clock edge: state RUN, both counters 0, mem_timeout 0, stall statistic 0; reset has priority over all events, including mid-stall.
REQ-027 After reset, with no events: pc_write_en=1, ifid_write_en=1, bubble_sel=0, ifid_flush=0, pipe_hold=0, mem_timeout=0.

Configuration
REQ-028 With HAZARD_CONTROL_STATS_EN defined: extra output stall_cycles, 16 bits, increments each cycle pc_write_en=0, saturates at 0xFFFF, cleared by reset.
REQ-029 Without HAZARD_CONTROL_STATS_EN: no stall_cycles port and no counter logic; all other behaviour identical.

Verification
REQ-030 ex_mem_read=1, ex_rd=5, id_rs=5, id_rs_valid=1, LOAD_STALL_CYCLES=1 -> exactly 1 cycle of pc_write_en=0, bubble_sel=1; then RUN outputs.
REQ-031 Same hazard, LOAD_STALL_CYCLES=3 -> 3 consecutive bubble cycles; branch_taken=1 in cycle 2 -> ifid_flush=1 that cycle and RUN next.
REQ-032 mem_busy high for 20 cycles, MEM_TIMEOUT=15 -> pipe_hold=1 for all 20; mem_timeout rises on the 15th cycle and stays 1 after mem_busy falls.
REQ-033 Hazard, branch_taken and mem_busy all asserted together -> pipe_hold=1, bubble_sel=0, ifid_flush=0.
REQ-034 ex_rd=0 with ex_mem_read=1 and id_rs=0 -> no stall; reset asserted mid LOAD_STALL -> RUN outputs on the next cycle.
REQ-035 With HAZARD_CONTROL_STATS_EN: 4 load-use stalls of 1 cycle plus 6 mem_busy cycles -> stall_cycles=10.
